// File: rtl/boton_evento_arbitro.sv
// Turns four debounced button levels into one-shot press / hold-repeat events and
// shares a single valid/ready event port among the buttons with round-robin priority.
module boton_evento_arbitro #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_db,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    output logic       ev_repeat,
    output logic [3:0] pending,
    output logic [3:0] overrun,
    output logic [8:0] dbg_state
);

    // Handshake: an event transfers on a clock edge where ev_valid and ev_ready are
    // both high; once raised, ev_valid, ev_code and ev_repeat hold until that edge.

    typedef enum logic [1:0] {H_REL = 2'd0, H_WAIT = 2'd1, H_RPT = 2'd2} hold_t;
    typedef enum logic {A_IDLE = 1'b0, A_OFFER = 1'b1} arb_t;

    localparam logic [25:0] HOLD_LAST   = 26'(HOLD_CYCLES - 1);
    localparam logic [25:0] REPEAT_LAST = 26'(REPEAT_CYCLES - 1);

    hold_t       hold_q [4];
    hold_t       hold_d [4];
    logic [25:0] cnt_q  [4];
    logic [25:0] cnt_d  [4];
    logic [3:0]  prev_q;
    logic [3:0]  press;
    logic [3:0]  set_ev;
    logic [3:0]  set_rep;

    arb_t       arb_q, arb_d;
    logic [1:0] last_q, last_d;
    logic [1:0] code_q, code_d;
    logic       erep_q, erep_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] rep_q, rep_d;
    logic [3:0] ovr_q, ovr_d;
    logic [3:0] clr;
    logic       hs;
    logic       grant_found;
    logic [1:0] grant;
    logic [1:0] idx;

    assign press = btn_db & ~prev_q;

    always_comb begin
        set_ev  = '0;
        set_rep = '0;
        for (int i = 0; i < 4; i++) begin
            hold_d[i] = hold_q[i];
            cnt_d[i]  = cnt_q[i];
            case (hold_q[i])
                H_REL: begin
                    cnt_d[i] = '0;
                    if (press[i]) begin
                        set_ev[i] = 1'b1;
                        hold_d[i] = H_WAIT;
                    end
                end
                H_WAIT: begin
                    if (!btn_db[i]) begin
                        hold_d[i] = H_REL;
                        cnt_d[i]  = '0;
                    end else if (cnt_q[i] == HOLD_LAST) begin
                        set_ev[i]  = 1'b1;
                        set_rep[i] = 1'b1;
                        cnt_d[i]   = '0;
                        hold_d[i]  = H_RPT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 26'd1;
                    end
                end
                H_RPT: begin
                    if (!btn_db[i]) begin
                        hold_d[i] = H_REL;
                        cnt_d[i]  = '0;
                    end else if (cnt_q[i] == REPEAT_LAST) begin
                        set_ev[i]  = 1'b1;
                        set_rep[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 26'd1;
                    end
                end
                default: begin
                    hold_d[i] = H_REL;
                    cnt_d[i]  = '0;
                end
            endcase
        end
    end

    // A set arriving in the same cycle its bit is handed off wins and is not an overrun.
    always_comb begin
        hs     = (arb_q == A_OFFER) && ev_ready;
        clr    = hs ? (4'b0001 << code_q) : 4'b0000;
        pend_d = (pend_q & ~clr) | set_ev;
        ovr_d  = ovr_q | (set_ev & pend_q & ~clr);
        rep_d  = (rep_q & ~set_ev) | (set_rep & set_ev);

        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!grant_found && pend_q[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end

        arb_d  = arb_q;
        last_d = last_q;
        code_d = code_q;
        erep_d = erep_q;
        case (arb_q)
            A_IDLE: begin
                if (grant_found) begin
                    code_d = grant;
                    erep_d = rep_q[grant];
                    arb_d  = A_OFFER;
                end
            end
            A_OFFER: begin
                if (ev_ready) begin
                    last_d = code_q;
                    arb_d  = A_IDLE;
                end
            end
            default: arb_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= H_REL;
                cnt_q[i]  <= '0;
            end
            prev_q <= '0;
            arb_q  <= A_IDLE;
            last_q <= 2'd3;
            code_q <= '0;
            erep_q <= 1'b0;
            pend_q <= '0;
            rep_q  <= '0;
            ovr_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= hold_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            prev_q <= btn_db;
            arb_q  <= arb_d;
            last_q <= last_d;
            code_q <= code_d;
            erep_q <= erep_d;
            pend_q <= pend_d;
            rep_q  <= rep_d;
            ovr_q  <= ovr_d;
        end
    end

    assign ev_valid  = (arb_q == A_OFFER);
    assign ev_code   = code_q;
    assign ev_repeat = erep_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;
    assign dbg_state = {arb_q, hold_q[3], hold_q[2], hold_q[1], hold_q[0]};

endmodule

// File: tb/tb_boton_evento_arbitro.sv
// Bench for boton_evento_arbitro: directed vector table, hand-written corner sequences
// and random stimulus against a timeline-based reference model.
`timescale 1ns/1ps
module tb_boton_evento_arbitro;

    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_db;
    logic       ev_ready;
    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_repeat;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic [8:0] dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    boton_evento_arbitro #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .reset(reset), .btn_db(btn_db), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_repeat(ev_repeat),
        .pending(pending), .overrun(overrun), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: events derived from press time and elapsed cycles.
    int         m_cyc;
    int         m_tp [4];
    logic [3:0] m_prev, m_pend, m_rep, m_ovr;
    logic       m_offer, m_orep;
    logic [1:0] m_code, m_last;

    task automatic model_reset();
        m_cyc = 0;
        for (int i = 0; i < 4; i++) m_tp[i] = -1;
        m_prev = '0; m_pend = '0; m_rep = '0; m_ovr = '0;
        m_offer = 1'b0; m_orep = 1'b0; m_code = '0; m_last = 2'd3;
    endtask

    task automatic model_edge(input logic [3:0] b, input logic r);
        logic [3:0] ev, evrep, pnext;
        int e, g;
        ev = '0; evrep = '0;
        for (int i = 0; i < 4; i++) begin
            if (b[i] && !m_prev[i]) begin
                ev[i] = 1'b1;
                m_tp[i] = m_cyc;
            end else if (b[i] && m_tp[i] >= 0) begin
                e = m_cyc - m_tp[i];
                if (e >= HOLD && (e - HOLD) % REP == 0) begin
                    ev[i] = 1'b1;
                    evrep[i] = 1'b1;
                end
            end
            if (!b[i]) m_tp[i] = -1;
        end
        pnext = m_pend;
        if (m_offer && r) pnext[m_code] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) begin
                if (pnext[i]) m_ovr[i] = 1'b1;
                pnext[i] = 1'b1;
            end
        end
        if (m_offer) begin
            if (r) begin
                m_offer = 1'b0;
                m_last = m_code;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                g = (int'(m_last) + k) % 4;
                if (m_pend[g]) begin
                    m_offer = 1'b1;
                    m_code = 2'(g);
                    m_orep = m_rep[g];
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++) if (ev[i]) m_rep[i] = evrep[i];
        m_pend = pnext;
        m_prev = b;
        m_cyc++;
    endtask

    task automatic step(input logic [3:0] b, input logic r);
        btn_db = b;
        ev_ready = r;
        @(posedge clk);
        model_edge(b, r);
        @(negedge clk);
        chk("mdl_valid", 32'(ev_valid), 32'(m_offer));
        chk("mdl_pending", 32'(pending), 32'(m_pend));
        chk("mdl_overrun", 32'(overrun), 32'(m_ovr));
        if (m_offer) begin
            chk("mdl_code", 32'(ev_code), 32'(m_code));
            chk("mdl_repeat", 32'(ev_repeat), 32'(m_orep));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_code", 32'(ev_code), 32'd0);
        chk("rst_repeat", 32'(ev_repeat), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic       rdy;
        logic       v;
        logic [1:0] code;
        logic       rep;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic [3:0] btn, input logic rdy,
                                input logic v, input logic [1:0] code, input logic rep,
                                input logic [3:0] pend);
        vec_t x;
        x.rst = rst; x.btn = btn; x.rdy = rdy; x.v = v; x.code = code; x.rep = rep; x.pend = pend;
        tbl.push_back(x);
    endfunction

    initial begin
        int n, cnt0, cnt3, prevc;
        int   rise_c[$];
        logic rise_r[$];
        logic [3:0] b;
        logic [1:0] hold_code;

        reset = 1'b1;
        btn_db = '0;
        ev_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Single short pulse on button 0, then all four buttons at once.
        add(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b0001, 1, 1, 0, 0, 4'b0001);
        add(0, 4'b0001, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b1111);
        add(0, 4'b1111, 1, 1, 0, 0, 4'b1111);
        add(0, 4'b1111, 1, 0, 0, 0, 4'b1110);
        add(0, 4'b1111, 1, 1, 1, 0, 4'b1110);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b1100);
        add(0, 4'b0000, 1, 1, 2, 0, 4'b1100);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b0000, 1, 1, 3, 0, 4'b1000);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                btn_db = tbl[i].btn;
                ev_ready = tbl[i].rdy;
                do_reset();
            end else begin
                step(tbl[i].btn, tbl[i].rdy);
            end
            chk("tbl_valid", 32'(ev_valid), 32'(tbl[i].v));
            chk("tbl_pending", 32'(pending), 32'(tbl[i].pend));
            if (tbl[i].v) begin
                chk("tbl_code", 32'(ev_code), 32'(tbl[i].code));
                chk("tbl_repeat", 32'(ev_repeat), 32'(tbl[i].rep));
            end
        end

        // Hold button 2 for 20 cycles: press, then repeats 8, 12 and 16 cycles later.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step((c < 20) ? 4'b0100 : 4'b0000, 1'b1);
            if (ev_valid) begin
                rise_c.push_back(c);
                rise_r.push_back(ev_repeat);
                chk("hold_code", 32'(ev_code), 32'd2);
            end
        end
        chk("hold_count", 32'(rise_c.size()), 32'd4);
        if (rise_c.size() >= 4) begin
            chk("hold_t0", 32'(rise_c[0]), 32'd1);
            chk("hold_t1", 32'(rise_c[1]), 32'd9);
            chk("hold_t2", 32'(rise_c[2]), 32'd13);
            chk("hold_t3", 32'(rise_c[3]), 32'd17);
            chk("hold_r0", 32'(rise_r[0]), 32'd0);
            chk("hold_r1", 32'(rise_r[1]), 32'd1);
            chk("hold_r3", 32'(rise_r[3]), 32'd1);
        end

        // Stalled offer of button 1 with a second press coalesced into it.
        do_reset();
        step(4'b0010, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step((c == 4) ? 4'b0010 : 4'b0000, 1'b0);
            chk("stall_valid", 32'(ev_valid), 32'd1);
            chk("stall_code", 32'(ev_code), 32'd1);
            chk("stall_repeat", 32'(ev_repeat), 32'd0);
        end
        chk("stall_overrun", 32'(overrun), 32'b0010);
        step(4'b0000, 1'b1);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            step(4'b0000, 1'b1);
            if (ev_valid) n++;
        end
        chk("stall_extra_events", 32'(n), 32'd0);
        chk("stall_pending", 32'(pending), 32'd0);
        chk("stall_overrun_sticky", 32'(overrun), 32'b0010);

        // Buttons 0 and 3 held in repeat: grants must alternate.
        do_reset();
        cnt0 = 0; cnt3 = 0; prevc = -1;
        for (int c = 0; c < 48; c++) begin
            step(4'b1001, 1'b1);
            if (ev_valid) begin
                if (prevc >= 0) chk("rr_alternate", 32'(ev_code == 2'(prevc)), 32'd0);
                prevc = int'(ev_code);
                if (ev_code == 2'd0) cnt0++;
                if (ev_code == 2'd3) cnt3++;
            end
        end
        chk("rr_btn0_served", 32'(cnt0 >= 10), 32'd1);
        chk("rr_btn3_served", 32'(cnt3 >= 10), 32'd1);
        chk("rr_overrun", 32'(overrun), 32'd0);

        // Reset asserted mid-offer drops everything; a still-held button re-presses.
        do_reset();
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        chk("rmo_offer_valid", 32'(ev_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rmo_valid", 32'(ev_valid), 32'd0);
        chk("rmo_pending", 32'(pending), 32'd0);
        chk("rmo_code", 32'(ev_code), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        hold_code = 2'd0;
        for (int c = 0; c < 12; c++) begin
            step((c < 3) ? 4'b0010 : 4'b0000, 1'b1);
            if (ev_valid) begin
                n++;
                hold_code = ev_code;
                chk("rmo_ev_repeat", 32'(ev_repeat), 32'd0);
            end
        end
        chk("rmo_ev_count", 32'(n), 32'd1);
        chk("rmo_ev_code", 32'(hold_code), 32'd1);

        // Random buttons and ready, checked against the model every cycle.
        do_reset();
        b = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 499) do_reset();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
            step(b, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boton_evento_arbitro.md
# boton_evento_arbitro

Converts the debounced level outputs of four pushbutton debouncers into a single stream of one-shot button events, with hold-to-repeat, and shares the one downstream event port among the four buttons using round-robin arbitration. Sits between the debounce stage and the control FSM that consumes user commands, so the consumer sees one coded event per press or repeat tick.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a button must stay high after its press before the first repeat (0.5 s at 100 MHz); legal range 2..2^26-1.
- REPEAT_CYCLES, 10_000_000: cycles between repeat events while held (0.1 s); legal range 2..2^26-1.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_db  in  4  debounced button levels, bit i = button i, synchronous to clk.
- ev_ready  in  1  consumer accepts the offered event this cycle.
- ev_valid  out  1  event offered.
- ev_code  out  2  index of the button owning the offered event.
- ev_repeat  out  1  1 = event is an auto-repeat, 0 = initial press.
- pending  out  4  per-button event waiting (includes the one being offered).
- overrun  out  4  sticky: an event for button i was coalesced into one already pending.

## Operation
- Per-button edge detect: btn_prev[i] registered, reset 0. Press = btn_db[i] & ~btn_prev[i]. A button high when reset releases yields one press event.
- Per-button hold FSM, 26-bit counter cnt[i]:
  - REL: cnt=0. On press -> set pending[i], rep[i]=0, go WAIT.
  - WAIT: cnt++ each cycle; at cnt==HOLD_CYCLES-1 -> set pending[i], rep[i]=1, cnt=0, go RPT.
  - RPT: cnt++; at cnt==REPEAT_CYCLES-1 -> set pending[i], rep[i]=1, cnt=0.
  - btn_db[i]==0 in WAIT or RPT -> REL, cnt=0. Already pending events are not dropped on release.
- Setting pending[i] while already 1: pending stays 1, rep[i] takes the newest value, overrun[i] sets (sticky until reset).
- Arbiter FSM:
  - IDLE: ev_valid=0. If pending!=0, grant the first set bit searching upward from (last+1) mod 4; latch ev_code and ev_repeat=rep[grant]; go OFFER.
  - OFFER: ev_valid=1, ev_code/ev_repeat stable. On ev_ready: clear pending[ev_code], last=ev_code, go IDLE. ev_valid never drops without ev_ready.
  - Simultaneous clear (handshake) and set for the same button in one cycle: set wins, pending stays 1, new rep value kept, overrun not flagged.
- last resets to 3, so button 0 has first priority.

## Timing
- Reset values: ev_valid=0, ev_code=0, ev_repeat=0, pending=0, overrun=0; all FSMs in REL/IDLE, counters 0.
- Press sampled at edge t0 -> pending[i]=1 after t0 -> arbiter grants at t1 -> ev_valid=1 after t1 (2-cycle latency from first high sample).
- Handshake at edge tH (ev_valid & ev_ready) -> ev_valid=0 after tH; next grant earliest at tH+1. Max throughput: one event per 2 cycles.
- First repeat: pending sets HOLD_CYCLES cycles after the press edge; subsequent repeats every REPEAT_CYCLES cycles.
- Reset mid-offer: ev_valid drops asynchronously; the offered event is lost and is not reissued.
- ev_ready while ev_valid=0: ignored.

## Test plan
- HOLD_CYCLES=8, REPEAT_CYCLES=4, ev_ready=1: pulse btn_db=0001 for 3 cycles -> exactly one event, ev_code=0, ev_repeat=0, valid 2 cycles after rise; no repeats.
- Same params, hold btn_db=0100 for 20 cycles -> press event code 2 rep 0, then repeat events (rep 1) at +8, +12, +16 cycles from press; none after release.
- btn_db 0000->1111 in one cycle, ev_ready=1 -> codes 0,1,2,3 in order, one event per 2 cycles, pending walks 1111->1110->1100->1000->0000.
- ev_ready=0 for 10 cycles while offering code 1 -> ev_valid, ev_code, ev_repeat held constant; a second press of button 1 sets overrun[1]=1; after ready, one event only for button 1.
- Round-robin fairness: buttons 0 and 3 both held in RPT with REPEAT_CYCLES=4, ev_ready=1 -> grants alternate, neither starved, no overrun.
- Assert reset during OFFER -> all outputs 0 immediately; after release with btn_db=0010 still high -> one press event code 1.
